// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM pipeline stage and the data memory.
// The stage drives the request side (master); the memory answers with
// read data and a ready strobe (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory loads/stores with byte-lane
// selection, stalls the pipe until the memory answers, and registers the
// MEM/WB fields on the falling clock edge.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS watchdog that aborts a
// request after TIMEOUT_CYCLES cycles without ready and raises an exception.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [31:0]         ALUShift_out_in,
  input  logic [31:0]         StoreData_in,
  input  logic [1:0]          LoadType_in,
  input  logic [1:0]          LoadByte_in,
  input  logic                MemWr_in,
  input  logic                MemtoReg_in,
  input  logic                RegWr_in,
  input  logic [4:0]          Rd_in,
  input  logic                Exception_in,
  input  logic                Overflow_in,
  mem_access_if.master        dmem,
  output logic                Mem_stall,
  output logic [31:0]         ALUShift_out_out,
  output logic [31:0]         MemData_out,
  output logic                RegWr_out,
  output logic                MemtoReg_out,
  output logic [4:0]          Rd_out,
  output logic                Exception_out
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] alu_q, alu_d, mdata_q, mdata_d;
  logic        regwr_q, regwr_d, mtr_q, mtr_d, exc_q, exc_d;
  logic [4:0]  rd_q, rd_d;

  logic        is_byte, is_half, is_word, misalign, mem_op, exc_any, valid_op;
  logic [1:0]  lane;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        req_c, timeout_hit;
  logic        unused_bits;

  // Sign- or zero-extend the addressed byte/half of a read word.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  ln,
                                               input logic        byte_op,
                                               input logic        half_op,
                                               input logic        zext);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    sh = rdata >> {ln, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    if (byte_op) begin
      sx = b;
      return zext ? {24'h0, sh[7:0]} : sx;
    end else if (half_op) begin
      sx = h;
      return zext ? {16'h0, sh[15:0]} : sx;
    end
    return rdata;
  endfunction

  assign lane     = ALUShift_out_in[1:0];
  assign is_byte  = (LoadType_in == 2'b10);
  assign is_half  = (LoadType_in == 2'b01);
  assign is_word  = !is_byte && !is_half;
  assign misalign = (is_half && lane[0]) || (is_word && lane != 2'b00);
  assign mem_op   = MemWr_in || MemtoReg_in;
  assign exc_any  = Exception_in || Overflow_in || (mem_op && misalign);
  assign valid_op = mem_op && !exc_any;

  // Lane enables and replicated store data for the addressed width.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = StoreData_in;
    if (is_byte) begin
      be_c    = 4'b0001 << lane;
      wdata_c = {4{StoreData_in[7:0]}};
    end else if (is_half) begin
      be_c    = 4'b0011 << lane;
      wdata_c = {2{StoreData_in[15:0]}};
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;

  assign timeout_hit = (state_q == ACCESS) && !dmem.dmem_ready && (wd_q == TO_LAST);

  // Count ACCESS cycles spent waiting; cleared whenever the access ends.
  always_comb begin
    wd_d = 8'd0;
    if (state_q == ACCESS && !dmem.dmem_ready && !timeout_hit) wd_d = wd_q + 8'd1;
  end

  // Watchdog register.
  always_ff @(negedge clk or negedge Reset) begin
    if (!Reset) wd_q <= 8'd0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign unused_bits = ^{LoadByte_in[1], TO_LAST};

  // Next state, request and stall; reset forces both low immediately.
  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    Mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_op) begin
          req_c     = 1'b1;
          Mem_stall = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        req_c     = 1'b1;
        Mem_stall = !dmem.dmem_ready && !timeout_hit;
        if (dmem.dmem_ready || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!Reset) begin
      req_c     = 1'b0;
      Mem_stall = 1'b0;
    end
  end

  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = req_c && MemWr_in;
  assign dmem.dmem_be    = req_c ? be_c : 4'b0000;
  assign dmem.dmem_addr  = {ALUShift_out_in[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_c;

  // MEM/WB field selection: bubble while stalled, exception on a
  // suppressed op or watchdog abort, otherwise pass through with load data.
  always_comb begin
    alu_d   = ALUShift_out_in;
    mdata_d = 32'h0;
    regwr_d = RegWr_in;
    mtr_d   = MemtoReg_in;
    rd_d    = Rd_in;
    exc_d   = 1'b0;
    if (Mem_stall) begin
      alu_d   = 32'h0;
      regwr_d = 1'b0;
      mtr_d   = 1'b0;
      rd_d    = 5'd0;
    end else if (timeout_hit || exc_any) begin
      regwr_d = 1'b0;
      mtr_d   = 1'b0;
      exc_d   = 1'b1;
    end else if (state_q == ACCESS && MemtoReg_in) begin
      mdata_d = load_extract(dmem.dmem_rdata, lane, is_byte, is_half, LoadByte_in[0]);
    end
  end

  // State and MEM/WB registers, updated on the falling edge.
  always_ff @(negedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      alu_q   <= 32'h0;
      mdata_q <= 32'h0;
      regwr_q <= 1'b0;
      mtr_q   <= 1'b0;
      rd_q    <= 5'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      regwr_q <= regwr_d;
      mtr_q   <= mtr_d;
      rd_q    <= rd_d;
      exc_q   <= exc_d;
    end
  end

  assign ALUShift_out_out = alu_q;
  assign MemData_out      = mdata_q;
  assign RegWr_out        = regwr_q;
  assign MemtoReg_out     = mtr_q;
  assign Rd_out           = rd_q;
  assign Exception_out    = exc_q;

endmodule
